// File: rtl/balance_pkg.sv
`default_nettype none
// ============================================================================
// Module      : balance_pkg
// Description : Shared types and state encoding for the balance sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package balance_pkg;

  localparam logic [2:0] c_ST_OFF    = 3'd0;
  localparam logic [2:0] c_ST_SETTLE = 3'd1;
  localparam logic [2:0] c_ST_RUN    = 3'd2;
  localparam logic [2:0] c_ST_DRAIN  = 3'd3;
  localparam logic [2:0] c_ST_FAULT  = 3'd4;

  typedef enum logic [2:0] {
    ST_OFF    = c_ST_OFF,
    ST_SETTLE = c_ST_SETTLE,
    ST_RUN    = c_ST_RUN,
    ST_DRAIN  = c_ST_DRAIN,
    ST_FAULT  = c_ST_FAULT
  } seq_state_t;

  typedef logic signed [11:0] spd_t;

endpackage
`default_nettype wire

// File: rtl/balance_seq_inflight_pipe.sv
`default_nettype none
// ============================================================================
// Module      : inflight_pipe
// Description : Valid shift register that follows samples through the
//               fixed-latency balance datapath and flags their arrival.
// Revision    : 1.0 - initial release
// ============================================================================
module inflight_pipe #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic vld_i,
  output logic cap_o,
  output logic outstanding_o
);

  logic [LAT-1:0] sr_q;
  logic [LAT-1:0] sr_d;

  generate
    if (LAT == 1) begin : g_lat1
      assign sr_d = vld_i;
    end else begin : g_latn
      assign sr_d = {sr_q[LAT-2:0], vld_i};
    end
  endgenerate

  // Advance the in-flight markers; reset or flush aborts every sample.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Top tap marks the cycle the datapath speeds belong to that sample.
  assign cap_o         = sr_q[LAT-1];
  assign outstanding_o = |sr_q;

endmodule
`default_nettype wire

// File: rtl/balance_seq.sv
`default_nettype none
// ============================================================================
// Module      : balance_seq
// Description : Sequencer around the balance datapath: gates sample strobes,
//               tracks in-flight samples, captures wheel speeds and runs the
//               OFF/SETTLE/RUN/DRAIN/FAULT state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module balance_seq
  import balance_pkg::*;
#(
  parameter int LAT        = 3,
  parameter int SETTLE_CYC = 256,
  parameter int TF_LIM     = 3,
  parameter int FLT_HOLD   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inert_vld,
  input  logic              rider_off,
  input  logic              batt_low,
  input  logic              en_steer_in,
  input  logic              too_fast,
  input  logic signed [11:0] lft_spd_in,
  input  logic signed [11:0] rght_spd_in,
  output logic              vld_out,
  output logic              pwr_up,
  output logic              en_steer,
  output logic signed [11:0] lft_spd,
  output logic signed [11:0] rght_spd,
  output logic              spd_vld,
  output logic              fault,
  output logic [2:0]        state
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int HW = $clog2(FLT_HOLD) + 1;
  localparam int TW = (TF_LIM > 0) ? $clog2(TF_LIM + 1) : 1;

  localparam logic [SW-1:0] c_SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [HW-1:0] c_HOLD_LAST   = HW'(FLT_HOLD - 1);
  localparam logic [HW-1:0] c_HOLD_MAX    = {HW{1'b1}};
  localparam logic [TW-1:0] c_TF_LIM      = TW'(TF_LIM);

  seq_state_t    state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] tf_q, tf_d, w_tf_next;
  logic          w_flush;
  logic          w_cap;
  logic          w_outstanding;
  logic          w_live_d;
  logic          w_pass;

  inflight_pipe #(
    .LAT (LAT)
  ) u_pipe (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (w_flush),
    .vld_i         (vld_out),
    .cap_o         (w_cap),
    .outstanding_o (w_outstanding)
  );

  // Next-state, counter updates and pipe flush on FAULT.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    hold_d    = hold_q;
    tf_d      = tf_q;
    w_tf_next = tf_q;
    if (w_cap && too_fast) begin
      w_tf_next = (tf_q == c_TF_LIM) ? tf_q : tf_q + 1'b1;
    end else if (w_cap) begin
      w_tf_next = '0;
    end
    case (state_q)
      ST_OFF: begin
        if (!rider_off && !batt_low) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (rider_off || batt_low)         state_d = ST_DRAIN;
        else if (settle_q == c_SETTLE_LAST) state_d = ST_RUN;
        else                                settle_d = settle_q + 1'b1;
      end
      ST_RUN: begin
        tf_d = w_tf_next;
        // Overspeed fault outranks a simultaneous rider/battery drop.
        if (w_cap && too_fast && (w_tf_next == c_TF_LIM)) state_d = ST_FAULT;
        else if (rider_off || batt_low)                   state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!w_outstanding) state_d = ST_OFF;
      end
      ST_FAULT: begin
        if ((hold_q >= c_HOLD_LAST) && rider_off) state_d = ST_OFF;
        else if (hold_q != c_HOLD_MAX)            hold_d = hold_q + 1'b1;
      end
      default: state_d = ST_OFF;
    endcase
    if (state_d != state_q) begin
      settle_d = '0;
      hold_d   = '0;
      tf_d     = '0;
    end
  end

  assign w_flush  = (state_d == ST_FAULT);
  assign w_live_d = (state_d == ST_SETTLE) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
  // Samples only enter the datapath while sampling stays enabled across the edge.
  assign w_pass   = ((state_q == ST_SETTLE) || (state_q == ST_RUN)) &&
                    ((state_d == ST_SETTLE) || (state_d == ST_RUN));

  // State, counters and outputs registered against the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_OFF;
      settle_q <= '0;
      hold_q   <= '0;
      tf_q     <= '0;
      vld_out  <= 1'b0;
      pwr_up   <= 1'b0;
      en_steer <= 1'b0;
      fault    <= 1'b0;
      spd_vld  <= 1'b0;
      lft_spd  <= '0;
      rght_spd <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      hold_q   <= hold_d;
      tf_q     <= tf_d;
      vld_out  <= inert_vld && w_pass;
      pwr_up   <= w_live_d;
      en_steer <= (state_d == ST_RUN) && en_steer_in;
      fault    <= (state_d == ST_FAULT);
      if (!w_live_d) begin
        spd_vld  <= 1'b0;
        lft_spd  <= '0;
        rght_spd <= '0;
      end else begin
        spd_vld <= w_cap;
        if (w_cap) begin
          lft_spd  <= lft_spd_in;
          rght_spd <= rght_spd_in;
        end
      end
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire
